// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path.
package cpu_ctrl_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_HALT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } seq_state_t;

endpackage

// File: rtl/tick_timeout_counter.sv
// Saturating 8-bit tick counter for the memory-wait watchdog.
// last flags one tick left before LIMIT; expired flags LIMIT reached.
module tick_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic last,
  output logic expired
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);
  localparam logic [7:0] LAST_C  = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign last    = (count == LAST_C);
  assign expired = (count == LIMIT_C);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with debug halt/step,
// memory-wait watchdog and retired-instruction counter; enables are one clk wide.
module cpu_phase_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_WIDTH     = 32,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic                   tick_n,
  input  logic                   run,
  input  logic                   step_req,
  input  logic                   halt_req,
  input  logic                   clear_fault,
  input  logic                   is_mem_op,
  input  logic                   mem_ready,
  output logic                   fetch_en,
  output logic                   decode_en,
  output logic                   exec_en,
  output logic                   mem_en,
  output logic                   wb_en,
  output logic                   pc_en,
  output logic                   mem_req,
  output logic [SEQ_STATE_W-1:0] state_o,
  output logic                   halted,
  output logic                   fault,
  output logic                   retire,
  output logic [CNT_WIDTH-1:0]   instret
);

  localparam seq_state_t RESET_STATE = START_RUNNING ? ST_FETCH : ST_HALT;

  seq_state_t state;
  logic       step_flag;
  logic       mem_flag;
  logic       tmo_clear;
  logic       tmo_inc;
  logic       tmo_last;
  logic       tmo_expired;

  // Count only missed-ready ticks while in MEMORY; anything else restarts the budget.
  assign tmo_inc   = (state == ST_MEMORY) && tick && !mem_ready;
  assign tmo_clear = (state != ST_MEMORY) || (tick && mem_ready);

  tick_timeout_counter #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .inc     (tmo_inc),
    .last    (tmo_last),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      step_flag <= 1'b0;
      mem_flag  <= 1'b0;
      instret   <= '0;
    end else begin
      case (state)
        // Debug exits are sampled every clk so a one-clk request is never lost.
        ST_HALT: begin
          if (!halt_req && (run || step_req)) begin
            state     <= ST_FETCH;
            step_flag <= !run;
          end
        end
        ST_FETCH: begin
          if (tick) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (tick) begin
            mem_flag <= is_mem_op;
            state    <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (tick) state <= mem_flag ? ST_MEMORY : ST_WRITEBACK;
        end
        ST_MEMORY: begin
          if (tick) begin
            if (mem_ready) begin
              state <= ST_WRITEBACK;
            end else if (tmo_last || tmo_expired) begin
              state <= ST_FAULT;
            end
          end
        end
        ST_WRITEBACK: begin
          if (tick) begin
            instret   <= instret + CNT_WIDTH'(1);
            step_flag <= 1'b0;
            state     <= (halt_req || step_flag) ? ST_HALT : ST_FETCH;
          end
        end
        ST_FAULT: begin
          if (clear_fault) state <= ST_HALT;
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

  // Gated by reset_n so a running reset state can never leak a partial enable.
  always_comb begin
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    pc_en     = 1'b0;
    mem_req   = 1'b0;
    retire    = 1'b0;
    if (reset_n) begin
      case (state)
        ST_FETCH:   fetch_en  = tick;
        ST_DECODE:  decode_en = tick;
        ST_EXECUTE: exec_en   = tick;
        ST_MEMORY: begin
          mem_req = 1'b1;
          mem_en  = tick && mem_ready;
        end
        ST_WRITEBACK: begin
          wb_en  = tick_n;
          pc_en  = tick;
          retire = tick;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;
  assign halted  = (state == ST_HALT);
  assign fault   = (state == ST_FAULT);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed vector bench for cpu_phase_sequencer (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_cpu_phase_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int CW = 4;

  localparam logic [1:0] PI = 2'b00;
  localparam logic [1:0] PT = 2'b10;
  localparam logic [1:0] PN = 2'b01;

  localparam logic [5:0] C_RUN = 6'b100000;
  localparam logic [5:0] C_STP = 6'b010000;
  localparam logic [5:0] C_HLT = 6'b001000;
  localparam logic [5:0] C_CLR = 6'b000100;
  localparam logic [5:0] C_MOP = 6'b000010;
  localparam logic [5:0] C_RDY = 6'b000001;

  localparam logic [7:0] O_F  = 8'h80;
  localparam logic [7:0] O_D  = 8'h40;
  localparam logic [7:0] O_E  = 8'h20;
  localparam logic [7:0] O_M  = 8'h10;
  localparam logic [7:0] O_W  = 8'h08;
  localparam logic [7:0] O_P  = 8'h04;
  localparam logic [7:0] O_RQ = 8'h02;
  localparam logic [7:0] O_R  = 8'h01;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0, tick_n = 1'b0;
  logic run = 1'b0, step_req = 1'b0, halt_req = 1'b0, clear_fault = 1'b0;
  logic is_mem_op = 1'b0, mem_ready = 1'b0;
  logic fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, mem_req;
  logic [SEQ_STATE_W-1:0] state_o;
  logic halted, fault, retire;
  logic [CW-1:0] instret;

  cpu_phase_sequencer #(
    .MEM_TIMEOUT   (4),
    .CNT_WIDTH     (CW),
    .START_RUNNING (1'b0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .tick_n      (tick_n),
    .run         (run),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .clear_fault (clear_fault),
    .is_mem_op   (is_mem_op),
    .mem_ready   (mem_ready),
    .fetch_en    (fetch_en),
    .decode_en   (decode_en),
    .exec_en     (exec_en),
    .mem_en      (mem_en),
    .wb_en       (wb_en),
    .pc_en       (pc_en),
    .mem_req     (mem_req),
    .state_o     (state_o),
    .halted      (halted),
    .fault       (fault),
    .retire      (retire),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ph;
    logic [5:0]    ctl;
    seq_state_t    st;
    logic [7:0]    out;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  function automatic void one(input logic [1:0] ph, input logic [5:0] ctl,
                              input seq_state_t st, input logic [7:0] out, input int cnt);
    vec_t v;
    v.ph  = ph;
    v.ctl = ctl;
    v.st  = st;
    v.out = out;
    v.cnt = cnt[CW-1:0];
    tbl.push_back(v);
  endfunction

  // One tick period: idle, tick_n, idle, tick; the state moves only after the tick.
  function automatic void period(input logic [5:0] ctl, input seq_state_t st,
                                 input logic [7:0] nout, input logic [7:0] tout, input int cnt);
    logic [7:0] lvl;
    lvl = (st == ST_MEMORY) ? O_RQ : 8'h00;
    one(PI, ctl, st, lvl, cnt);
    one(PN, ctl, st, nout, cnt);
    one(PI, ctl, st, lvl, cnt);
    one(PT, ctl, st, tout, cnt);
  endfunction

  function automatic void instr(input logic [5:0] ctl, input int cnt);
    period(ctl, ST_FETCH,     8'h00, O_F,       cnt);
    period(ctl, ST_DECODE,    8'h00, O_D,       cnt);
    period(ctl, ST_EXECUTE,   8'h00, O_E,       cnt);
    period(ctl, ST_WRITEBACK, O_W,   O_P | O_R, cnt);
  endfunction

  task automatic check_vec(input string name, input seq_state_t st,
                           input logic [7:0] out, input logic [CW-1:0] cnt);
    logic [7:0] got;
    got = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, mem_req, retire};
    checks++;
    if (state_o !== st || got !== out || halted !== (st == ST_HALT) ||
        fault !== (st == ST_FAULT) || instret !== cnt) begin
      errors++;
      $display("FAIL %s: got state=%0d out=%b halted=%b fault=%b instret=%0d, want state=%0d out=%b instret=%0d",
               name, state_o, got, halted, fault, instret, st, out, cnt);
    end
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      {tick, tick_n} = tbl[i].ph;
      {run, step_req, halt_req, clear_fault, is_mem_op, mem_ready} = tbl[i].ctl;
      #2;
      check_vec($sformatf("vec%0d", vec_no), tbl[i].st, tbl[i].out, tbl[i].cnt);
      vec_no++;
    end
    tbl.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1);
  end

  initial begin
    // Reset held with a tick present: no enables, HALT, zero count.
    tick = 1'b1;
    #2;
    check_vec("reset_state", ST_HALT, 8'h00, 0);
    @(negedge clk);
    tick = 1'b0;
    reset_n = 1'b1;

    // Debug priority in HALT, then a plain ALU instruction with stray inputs.
    one(PT, 6'd0,          ST_HALT, 8'h00, 0);
    one(PI, C_RUN | C_HLT, ST_HALT, 8'h00, 0);
    one(PN, C_STP | C_HLT, ST_HALT, 8'h00, 0);
    one(PI, C_CLR,         ST_HALT, 8'h00, 0);
    one(PI, C_RUN,         ST_HALT, 8'h00, 0);
    period(C_MOP,         ST_FETCH,     8'h00, O_F,       0);
    period(6'd0,          ST_DECODE,    8'h00, O_D,       0);
    period(C_MOP | C_RDY, ST_EXECUTE,   8'h00, O_E,       0);
    period(C_RDY,         ST_WRITEBACK, O_W,   O_P | O_R, 0);
    // Load: three missed ticks then ready on the fourth, one short of the limit.
    period(6'd0,  ST_FETCH,   8'h00, O_F, 1);
    period(C_MOP, ST_DECODE,  8'h00, O_D, 1);
    period(6'd0,  ST_EXECUTE, 8'h00, O_E, 1);
    for (int k = 0; k < 3; k++) period(6'd0, ST_MEMORY, O_RQ, O_RQ, 1);
    period(C_RDY, ST_MEMORY,    O_RQ, O_RQ | O_M, 1);
    period(6'd0,  ST_WRITEBACK, O_W,  O_P | O_R,  1);
    // halt_req raised in EXECUTE still retires the instruction.
    period(6'd0,  ST_FETCH,     8'h00, O_F,       2);
    period(6'd0,  ST_DECODE,    8'h00, O_D,       2);
    period(C_HLT, ST_EXECUTE,   8'h00, O_E,       2);
    period(C_HLT, ST_WRITEBACK, O_W,   O_P | O_R, 2);
    one(PT, 6'd0, ST_HALT, 8'h00, 3);
    one(PI, 6'd0, ST_HALT, 8'h00, 3);
    // Single step: one instruction then back to HALT.
    one(PI, C_STP, ST_HALT, 8'h00, 3);
    instr(6'd0, 3);
    one(PT, 6'd0, ST_HALT, 8'h00, 4);
    one(PN, 6'd0, ST_HALT, 8'h00, 4);
    // run and step together: run wins, keeps going past the first retire.
    one(PI, C_RUN | C_STP, ST_HALT, 8'h00, 4);
    instr(6'd0, 4);
    period(6'd0,  ST_FETCH,   8'h00, O_F,  5);
    period(C_MOP, ST_DECODE,  8'h00, O_D,  5);
    period(6'd0,  ST_EXECUTE, 8'h00, O_E,  5);
    period(6'd0,  ST_MEMORY,  O_RQ,  O_RQ, 5);
    apply_tbl();

    // Asynchronous reset in the middle of a memory wait.
    @(negedge clk);
    {tick, tick_n} = PT;
    {run, step_req, halt_req, clear_fault, is_mem_op, mem_ready} = 6'd0;
    #1;
    check_vec("mem_before_reset", ST_MEMORY, O_RQ, 5);
    reset_n = 1'b0;
    #1;
    check_vec("async_reset", ST_HALT, 8'h00, 0);
    @(negedge clk);
    tick = 1'b0;
    reset_n = 1'b1;

    // Stays halted until run; then one instruction and a load that times out.
    period(6'd0, ST_HALT, 8'h00, 8'h00, 0);
    period(6'd0, ST_HALT, 8'h00, 8'h00, 0);
    one(PI, C_RUN, ST_HALT, 8'h00, 0);
    instr(6'd0, 0);
    period(6'd0,  ST_FETCH,   8'h00, O_F, 1);
    period(C_MOP, ST_DECODE,  8'h00, O_D, 1);
    period(6'd0,  ST_EXECUTE, 8'h00, O_E, 1);
    for (int k = 0; k < 4; k++) period(6'd0, ST_MEMORY, O_RQ, O_RQ, 1);
    period(C_RDY, ST_FAULT, 8'h00, 8'h00, 1);
    one(PI, C_RUN | C_STP, ST_FAULT, 8'h00, 1);
    one(PI, C_CLR,         ST_FAULT, 8'h00, 1);
    one(PT, 6'd0,          ST_HALT,  8'h00, 1);
    apply_tbl();

    // Free-run sixteen instructions so the 4-bit counter wraps back to 1.
    one(PI, C_RUN, ST_HALT, 8'h00, 1);
    for (int k = 0; k < 16; k++) instr(6'd0, (1 + k) % 16);
    instr(C_HLT, 1);
    one(PT, 6'd0, ST_HALT, 8'h00, 2);
    apply_tbl();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
